anomaly_alert_manager: RTL and testbench
========================================

ANOMALY_ALERT_MANAGER -- requirements
Module: anomaly_alert_manager

Interface
REQ-001 The block SHALL expose parameter CONF_THRESH, default 8'd64, the minimum ml_confidence for a detection to qualify.
REQ-002 The block SHALL expose parameter CONFIRM_N, default 2, range 1..7, the consecutive same-class qualified detections required to raise an alert.
REQ-003 The block SHALL expose parameter HOLDOFF_CYCLES, default 16, range 1..255, the clock cycles of cooldown after an alert.
REQ-004 The block SHALL expose parameter FIFO_DEPTH, default 4, power of two, the alert queue depth.
REQ-005 Ports, in order:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ml_class  in  3  classifier result; 0=NORMAL, 1..5=anomaly classes.
- ml_confidence  in  8  classifier confidence.
- ml_valid  in  1  one-cycle strobe qualifying ml_class/ml_confidence.
- alert_ready  in  1  consumer accepts the head alert.
- alert_valid  out  1  head alert present.
- alert_class  out  3  head alert class.
- alert_conf  out  8  head alert peak confidence.
- alert_ts  out  16  head alert timestamp.
- alert_active  out  1  high while in HOLDOFF.
- overflow_cnt  out  8  count of dropped alerts, saturating.

Function
REQ-006 A free-running 16-bit timestamp SHALL increment every cycle and wrap from 16'hFFFF to 0.
REQ-007 A detection SHALL qualify iff ml_valid=1, ml_class!=0 and ml_class<=5, and ml_confidence>=CONF_THRESH.
REQ-008 The FSM SHALL have states IDLE, CONFIRM and HOLDOFF, and the block SHALL reset into IDLE.
REQ-009 In IDLE, a qualified detection SHALL do all of the following:
- load cand_class=ml_class, cnt=1, peak=ml_confidence;
- if CONFIRM_N=1, fire immediately (REQ-013);
- otherwise, go to CONFIRM.
REQ-010 In CONFIRM, a qualified detection with ml_class=cand_class SHALL increment cnt and update peak=max(peak, ml_confidence); when cnt reaches CONFIRM_N it SHALL fire in that cycle.
REQ-011 In CONFIRM, a qualified detection of a different class SHALL restart with cand_class=ml_class, cnt=1, peak=ml_confidence, and the FSM SHALL stay in CONFIRM.
REQ-012 In CONFIRM, a non-qualified ml_valid SHALL return the FSM to IDLE; cycles with ml_valid=0 SHALL hold state, cnt and peak unchanged.
REQ-013 Firing SHALL do all of the following in the same cycle:
- push {cand_class, peak including the current sample, current timestamp} into the FIFO;
- load holdoff=HOLDOFF_CYCLES;
- enter HOLDOFF.
REQ-014 In HOLDOFF, holdoff SHALL decrement each cycle and all ml_valid SHALL be ignored; when holdoff=1 the FSM SHALL return to IDLE on the next edge, giving exactly HOLDOFF_CYCLES cycles in HOLDOFF.
REQ-015 alert_active SHALL be 1 exactly while the FSM is in HOLDOFF.
REQ-016 The FIFO SHALL be first-word-fall-through: alert_valid=!empty, and the head fields SHALL be driven from the head entry.
REQ-017 A pushed alert SHALL appear on alert_valid on the cycle after the firing edge (latency 1 cycle from the final confirming ml_valid).
REQ-018 A pop SHALL occur iff alert_valid && alert_ready; head fields SHALL stay stable while alert_valid && !alert_ready.
REQ-019 A push when full without a same-cycle pop SHALL be dropped and SHALL increment overflow_cnt, which saturates at 255.
REQ-020 A push when full with a same-cycle pop SHALL be accepted.
REQ-021 A simultaneous push and pop when empty SHALL leave the FIFO holding the new entry.
REQ-022 A pop when empty SHALL be impossible, since alert_valid=0.

Reset
REQ-023 On rst_n=0, asynchronously:
- FSM=IDLE;
- cnt, peak, cand_class, holdoff, timestamp and overflow_cnt = 0;
- FIFO empty;
- all outputs = 0.
REQ-024 Reset asserted mid-CONFIRM or mid-HOLDOFF SHALL discard the pending candidate and all queued alerts.
REQ-025 The first rising edge after rst_n deasserts SHALL operate normally.

Structure
REQ-026 The shared package nanotrade_pkg SHALL define:
- the class code constants (CLS_NORMAL..CLS_QUOTE_STUFF);
- the FSM state encoding;
- the alert entry width (27 bits: class 3, conf 8, ts 16).
REQ-027 The FIFO SHALL be a sub-module named alert_fifo (synchronous, parameterised width/depth, full/empty flags, pointer wrap via an extra MSB).

Verification
REQ-028 With defaults, ml_valid pulses of class 2 at conf 80 then 100 -> one alert {2, 100, ts of second pulse}, alert_active high 16 cycles, then IDLE.
REQ-029 Class 1 at conf 80, then class 3 at conf 90, then class 3 at conf 70 -> single alert {3, 90}, with no alert for class 1.
REQ-030 Class 4 at conf 63 (below threshold) twice -> no alert; class 4 at conf 64 twice -> one alert.
REQ-031 With alert_ready=0 and five alerts fired (each separated by holdoff) -> four queued in order, overflow_cnt=1; then alert_ready=1 -> four pops in FIFO order, alert_valid=0.
REQ-032 FIFO full and the fifth fire coinciding with a pop -> push accepted and overflow_cnt unchanged; timestamp wrap from 16'hFFFF to 0 -> reported correctly.
REQ-033 rst_n pulsed low mid-HOLDOFF with two alerts queued -> alert_valid=0, alert_active=0, overflow_cnt=0 immediately.

Source files
------------

// File: rtl/nanotrade_pkg.sv
// Shared definitions for the anomaly alert path: class codes, FSM encoding, alert entry layout.
package nanotrade_pkg;

    // Classifier result codes; anything above CLS_QUOTE_STUFF is not a valid anomaly class.
    localparam logic [2:0] CLS_NORMAL      = 3'd0;
    localparam logic [2:0] CLS_SPOOFING    = 3'd1;
    localparam logic [2:0] CLS_LAYERING    = 3'd2;
    localparam logic [2:0] CLS_WASH_TRADE  = 3'd3;
    localparam logic [2:0] CLS_MOMENTUM    = 3'd4;
    localparam logic [2:0] CLS_QUOTE_STUFF = 3'd5;

    localparam int unsigned CLASS_W = 3;
    localparam int unsigned CONF_W  = 8;
    localparam int unsigned TS_W    = 16;
    localparam int unsigned ENTRY_W = CLASS_W + CONF_W + TS_W;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StConfirm = 2'd1,
        StHoldoff = 2'd2
    } aam_state_e;

    typedef struct packed {
        logic [CLASS_W-1:0] cls;
        logic [CONF_W-1:0]  conf;
        logic [TS_W-1:0]    ts;
    } alert_entry_t;

    function automatic logic [CONF_W-1:0] max_conf(input logic [CONF_W-1:0] a,
                                                   input logic [CONF_W-1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/alert_fifo.sv
// First-word-fall-through FIFO; pointers carry an extra MSB to tell full from empty.
module alert_fifo #(
    parameter int unsigned WIDTH = 27,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_wptr == r_rptr);
    assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_do_pop  = i_pop && !o_empty;
    // A push into a full FIFO is still accepted when the head leaves in the same cycle.
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_rdata   = r_mem[r_rptr[AW-1:0]];

    // Pointer update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + {{AW{1'b0}}, 1'b1};
            if (w_do_pop)  r_rptr <= r_rptr + {{AW{1'b0}}, 1'b1};
        end
    end

    // Storage write; contents are don't-care while the slot is unoccupied.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_wdata;
    end

endmodule

// File: rtl/anomaly_alert_manager.sv
// Confirms repeated same-class anomaly detections, raises queued alerts and enforces a cooldown.
module anomaly_alert_manager
    import nanotrade_pkg::*;
#(
    parameter logic [7:0]  CONF_THRESH    = 8'd64,
    parameter int unsigned CONFIRM_N      = 2,
    parameter int unsigned HOLDOFF_CYCLES = 16,
    parameter int unsigned FIFO_DEPTH     = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  ml_class,
    input  logic [7:0]  ml_confidence,
    input  logic        ml_valid,
    input  logic        alert_ready,
    output logic        alert_valid,
    output logic [2:0]  alert_class,
    output logic [7:0]  alert_conf,
    output logic [15:0] alert_ts,
    output logic        alert_active,
    output logic [7:0]  overflow_cnt
);
    localparam logic [2:0] CONFIRM_N_L = 3'(CONFIRM_N);
    localparam logic [7:0] HOLDOFF_L   = 8'(HOLDOFF_CYCLES);

    aam_state_e         r_state, w_state_next;
    logic [2:0]         r_cnt, w_cnt_next;
    logic [7:0]         r_peak, w_peak_next;
    logic [2:0]         r_cand, w_cand_next;
    logic [7:0]         r_holdoff, w_holdoff_next;
    logic [15:0]        r_ts;
    logic [7:0]         r_ovf;
    logic               w_qual;
    logic               w_fire;
    logic               w_full;
    logic               w_empty;
    logic               w_pop;
    logic [ENTRY_W-1:0] w_push_entry;
    logic [ENTRY_W-1:0] w_head_raw;
    alert_entry_t       w_head;

    assign w_qual = ml_valid && (ml_class != CLS_NORMAL) && (ml_class <= CLS_QUOTE_STUFF)
                    && (ml_confidence >= CONF_THRESH);

    // Next-state logic: candidate tracking, firing and cooldown countdown.
    always_comb begin
        w_state_next   = r_state;
        w_cnt_next     = r_cnt;
        w_peak_next    = r_peak;
        w_cand_next    = r_cand;
        w_holdoff_next = r_holdoff;
        w_fire         = 1'b0;
        case (r_state)
            StIdle: begin
                if (w_qual) begin
                    w_cand_next = ml_class;
                    w_cnt_next  = 3'd1;
                    w_peak_next = ml_confidence;
                    if (CONFIRM_N_L == 3'd1) w_fire = 1'b1;
                    else                     w_state_next = StConfirm;
                end
            end
            StConfirm: begin
                if (w_qual) begin
                    if (ml_class == r_cand) begin
                        w_cnt_next  = r_cnt + 3'd1;
                        w_peak_next = max_conf(r_peak, ml_confidence);
                        if (w_cnt_next == CONFIRM_N_L) w_fire = 1'b1;
                    end else begin
                        w_cand_next = ml_class;
                        w_cnt_next  = 3'd1;
                        w_peak_next = ml_confidence;
                    end
                end else if (ml_valid) begin
                    w_state_next = StIdle;
                end
            end
            StHoldoff: begin
                w_holdoff_next = r_holdoff - 8'd1;
                if (r_holdoff == 8'd1) w_state_next = StIdle;
            end
            default: w_state_next = StIdle;
        endcase
        if (w_fire) begin
            w_state_next   = StHoldoff;
            w_holdoff_next = HOLDOFF_L;
        end
    end

    // The pushed peak already includes the sample that completed confirmation.
    assign w_push_entry = {w_cand_next, w_peak_next, r_ts};
    assign w_pop        = !w_empty && alert_ready;

    alert_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_alert_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_fire),
        .i_wdata (w_push_entry),
        .i_pop   (w_pop),
        .o_rdata (w_head_raw),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // State, timestamp and drop counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= StIdle;
            r_cnt     <= '0;
            r_peak    <= '0;
            r_cand    <= '0;
            r_holdoff <= '0;
            r_ts      <= '0;
            r_ovf     <= '0;
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_peak    <= w_peak_next;
            r_cand    <= w_cand_next;
            r_holdoff <= w_holdoff_next;
            r_ts      <= r_ts + 16'd1;
            if (w_fire && w_full && !w_pop && (r_ovf != 8'hFF)) r_ovf <= r_ovf + 8'd1;
        end
    end

    // Head fields are forced to zero while empty so stale storage never leaks out.
    assign w_head       = alert_entry_t'(w_head_raw);
    assign alert_valid  = !w_empty;
    assign alert_class  = w_empty ? 3'd0  : w_head.cls;
    assign alert_conf   = w_empty ? 8'd0  : w_head.conf;
    assign alert_ts     = w_empty ? 16'd0 : w_head.ts;
    assign alert_active = (r_state == StHoldoff);
    assign overflow_cnt = r_ovf;

endmodule

// File: tb/tb_anomaly_alert_manager.sv
// Scoreboard bench: a cycle-level behavioural model predicts alerts; a negedge monitor checks.
module tb_anomaly_alert_manager;

    localparam int THRESH = 64;
    localparam int N      = 2;
    localparam int HOLD   = 16;
    localparam int DEPTH  = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  ml_class = '0;
    logic [7:0]  ml_confidence = '0;
    logic        ml_valid = 1'b0;
    logic        alert_ready = 1'b0;
    logic        alert_valid;
    logic [2:0]  alert_class;
    logic [7:0]  alert_conf;
    logic [15:0] alert_ts;
    logic        alert_active;
    logic [7:0]  overflow_cnt;

    anomaly_alert_manager dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ml_class      (ml_class),
        .ml_confidence (ml_confidence),
        .ml_valid      (ml_valid),
        .alert_ready   (alert_ready),
        .alert_valid   (alert_valid),
        .alert_class   (alert_class),
        .alert_conf    (alert_conf),
        .alert_ts      (alert_ts),
        .alert_active  (alert_active),
        .overflow_cnt  (overflow_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cls;
        int conf;
        int ts;
    } exp_t;

    exp_t        exp_q[$];
    int          occ;          // alerts the model believes are queued
    int          hold_left;    // cooldown cycles still to run
    int          streak_cnt;   // consecutive same-class qualified detections
    int          streak_cls;
    int          streak_peak;
    logic [15:0] m_ts;
    int          m_ovf;
    int          n_tests = 0;
    int          n_fail = 0;
    bit          mon_en = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        exp_q.delete();
        occ = 0; hold_left = 0; streak_cnt = 0; streak_cls = 0; streak_peak = 0;
        m_ts = 16'd0; m_ovf = 0;
    endtask

    // Effect of one rising edge given the inputs presented during the cycle before it.
    task automatic model_edge(input bit v, input int c, input int cf, input bit rdy);
        bit   pop;
        bit   fire;
        exp_t e;
        pop  = (occ > 0) && rdy;
        fire = 1'b0;
        if (hold_left > 0) begin
            hold_left--;
        end else if (v) begin
            if (c >= 1 && c <= 5 && cf >= THRESH) begin
                if (streak_cnt > 0 && c == streak_cls) begin
                    streak_cnt++;
                    if (cf > streak_peak) streak_peak = cf;
                end else begin
                    streak_cnt = 1; streak_cls = c; streak_peak = cf;
                end
                if (streak_cnt == N) begin
                    fire = 1'b1;
                    e.cls = streak_cls; e.conf = streak_peak; e.ts = int'(m_ts);
                    streak_cnt = 0;
                    hold_left = HOLD;
                end
            end else begin
                streak_cnt = 0;
            end
        end
        if (pop) occ--;
        if (fire) begin
            if (occ < DEPTH) begin
                exp_q.push_back(e);
                occ++;
            end else if (m_ovf < 255) begin
                m_ovf++;
            end
        end
        m_ts = m_ts + 16'd1;
    endtask

    // One clock: drive inputs just after an edge, advance the model at the next edge.
    task automatic cyc(input bit v, input int c, input int cf, input bit rdy);
        ml_valid      = v;
        ml_class      = 3'(c);
        ml_confidence = 8'(cf);
        alert_ready   = rdy;
        @(posedge clk);
        model_edge(v, c, cf, rdy);
        #1;
    endtask

    task automatic idle(input int n, input bit rdy);
        repeat (n) cyc(1'b0, 0, 0, rdy);
    endtask

    task automatic fire_pair(input int c, input int c1, input int c2, input bit rdy);
        cyc(1'b1, c, c1, rdy);
        cyc(1'b1, c, c2, rdy);
    endtask

    task automatic do_reset();
        mon_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        check("rst_alert_valid", int'(alert_valid), 0);
        check("rst_alert_active", int'(alert_active), 0);
        check("rst_overflow_cnt", int'(overflow_cnt), 0);
        check("rst_alert_fields", int'({alert_class, alert_conf, alert_ts}), 0);
        model_clear();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        mon_en = 1'b1;
    endtask

    // Monitor: mid-cycle, compare flags and pop the scoreboard on each accepted alert.
    always @(negedge clk) begin
        if (rst_n && mon_en) begin
            check("alert_valid", int'(alert_valid), int'(occ > 0));
            check("alert_active", int'(alert_active), int'(hold_left > 0));
            check("overflow_cnt", int'(overflow_cnt), m_ovf);
            if (alert_valid && alert_ready) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL alert_pop: got an alert, expected none (t=%0t)", $time);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("alert_class", int'(alert_class), e.cls);
                    check("alert_conf", int'(alert_conf), e.conf);
                    check("alert_ts", int'(alert_ts), e.ts);
                end
            end
        end
    end

    initial begin
        int rdy_pct;
        model_clear();
        do_reset();

        // Two class-2 pulses -> one alert with the higher peak, then full cooldown.
        fire_pair(2, 80, 100, 1'b1);
        idle(20, 1'b1);

        // Class change restarts the candidate; the third pulse confirms class 3.
        cyc(1'b1, 1, 80, 1'b1);
        cyc(1'b1, 3, 90, 1'b1);
        cyc(1'b1, 3, 70, 1'b1);
        idle(20, 1'b1);

        // Threshold boundary: 63 never qualifies, 64 does.
        fire_pair(4, 63, 63, 1'b1);
        idle(3, 1'b1);
        fire_pair(4, 64, 64, 1'b1);
        idle(20, 1'b1);

        // Five alerts with consumer stalled: four queue, one dropped, then drain.
        repeat (5) begin
            fire_pair(5, 120, 130, 1'b0);
            idle(17, 1'b0);
        end
        idle(10, 1'b1);

        // Full FIFO with the fifth fire coinciding with a pop: accepted.
        for (int i = 0; i < 4; i++) begin
            fire_pair(i + 1, 100 + i, 90, 1'b0);
            idle(17, 1'b0);
        end
        cyc(1'b1, 1, 200, 1'b0);
        cyc(1'b1, 1, 210, 1'b1);
        idle(17, 1'b0);
        idle(8, 1'b1);

        // Random traffic with varying consumer back-pressure.
        for (int blk = 0; blk < 9; blk++) begin
            rdy_pct = (blk % 3 == 0) ? 85 : ((blk % 3 == 1) ? 5 : 50);
            for (int k = 0; k < 180; k++) begin
                cyc(1'($urandom_range(0, 99) < 60), int'($urandom_range(0, 6)),
                    int'($urandom_range(40, 255)), 1'($urandom_range(0, 99) < rdy_pct));
            end
        end
        idle(30, 1'b1);

        // Reset in the middle of cooldown with two alerts queued.
        fire_pair(3, 150, 160, 1'b0);
        idle(17, 1'b0);
        fire_pair(2, 170, 99, 1'b0);
        idle(3, 1'b0);
        do_reset();
        idle(5, 1'b1);

        // Timestamp wrap: run quietly up to the top of the range.
        mon_en = 1'b0;
        while (m_ts != 16'hFFFE) idle(1, 1'b1);
        mon_en = 1'b1;
        fire_pair(1, 77, 88, 1'b1);
        idle(16, 1'b1);
        fire_pair(5, 255, 200, 1'b1);
        idle(20, 1'b1);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
